// File: rtl/fx2_cmd_decoder.sv
// rtl/fx2_cmd_decoder.sv - framed FX2 command words to 32-bit memory bus accesses
// Read data returns as a 16-bit valid/ready response stream.
module fx2_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_WIDTH  = 11
) (
  input  logic        fx2_ifclk,
  input  logic        reset_n,
  input  logic [15:0] command_rx_data,
  input  logic        command_rx_req,
  output logic        command_rx_ack,
  input  logic        command_rx_valid,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [15:0] resp_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        cmd_error,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_HDR, S_AHI, S_ALO, S_DLO, S_DHI, S_BUS, S_ECHO, S_RLO, S_RHI, S_DRAIN
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] T_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state, state_nx;
  logic [15:0]              hdr, hdr_nx;
  logic [7:0]               cnt, cnt_nx;
  logic [31:0]              addr, addr_nx, wdata, wdata_nx, rdata, rdata_nx;
  logic [8:0]               drain, drain_nx;
  logic [TIMEOUT_WIDTH-1:0] tcnt, tcnt_nx;
  logic                     ack_nx, err_nx;
  logic                     accepting, capture, word_ok, is_write;

  assign accepting = (state == S_HDR) || (state == S_AHI) || (state == S_ALO) ||
                     (state == S_DLO) || (state == S_DHI) || (state == S_DRAIN);
  assign capture   = command_rx_req && !command_rx_ack && accepting;
  assign word_ok   = capture && command_rx_valid;
  assign is_write  = (hdr[15:12] == 4'h1);

  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_HDR;
      hdr            <= '0;
      cnt            <= '0;
      addr           <= '0;
      wdata          <= '0;
      rdata          <= '0;
      drain          <= '0;
      tcnt           <= '0;
      command_rx_ack <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      state          <= state_nx;
      hdr            <= hdr_nx;
      cnt            <= cnt_nx;
      addr           <= addr_nx;
      wdata          <= wdata_nx;
      rdata          <= rdata_nx;
      drain          <= drain_nx;
      tcnt           <= tcnt_nx;
      command_rx_ack <= ack_nx;
      cmd_error      <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hdr_nx   = hdr;
    cnt_nx   = cnt;
    addr_nx  = addr;
    wdata_nx = wdata;
    rdata_nx = rdata;
    drain_nx = drain;
    tcnt_nx  = '0;
    err_nx   = 1'b0;
    // Ack completes the four-phase cycle even after the FSM leaves an accepting state.
    if (capture)              ack_nx = 1'b1;
    else if (!command_rx_req) ack_nx = 1'b0;
    else                      ack_nx = command_rx_ack;
    if (capture && !command_rx_valid) err_nx = 1'b1;

    case (state)
      S_HDR: if (word_ok) begin
        case (command_rx_data[15:12])
          4'h0: ;
          4'h1, 4'h2: begin
            hdr_nx   = command_rx_data;
            cnt_nx   = command_rx_data[7:0];
            state_nx = S_AHI;
          end
          default: err_nx = 1'b1;
        endcase
      end
      S_AHI: if (word_ok) begin
        addr_nx[31:16] = command_rx_data;
        state_nx       = S_ALO;
      end
      S_ALO: if (word_ok) begin
        addr_nx[15:0] = {command_rx_data[15:2], 2'b00};
        if (cnt == 8'd0)   state_nx = S_HDR;
        else if (is_write) state_nx = S_DLO;
        else               state_nx = S_ECHO;
      end
      S_DLO: if (word_ok) begin
        wdata_nx[15:0] = command_rx_data;
        state_nx       = S_DHI;
      end
      S_DHI: if (word_ok) begin
        wdata_nx[31:16] = command_rx_data;
        state_nx        = S_BUS;
      end
      S_BUS: begin
        if (mem_ready) begin
          if (is_write) begin
            addr_nx  = addr + 32'd4;
            cnt_nx   = cnt - 8'd1;
            state_nx = (cnt == 8'd1) ? S_HDR : S_DLO;
          end else begin
            rdata_nx = mem_rdata;
            state_nx = S_RLO;
          end
        end else if (tcnt == T_LAST) begin
          err_nx = 1'b1;
          // Host keeps sending the rest of a write; swallow those data words.
          if (is_write && cnt != 8'd1) begin
            drain_nx = {cnt - 8'd1, 1'b0};
            state_nx = S_DRAIN;
          end else begin
            state_nx = S_HDR;
          end
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      S_ECHO: if (resp_ready) state_nx = S_BUS;
      S_RLO:  if (resp_ready) state_nx = S_RHI;
      S_RHI: if (resp_ready) begin
        addr_nx  = addr + 32'd4;
        cnt_nx   = cnt - 8'd1;
        state_nx = (cnt == 8'd1) ? S_HDR : S_BUS;
      end
      S_DRAIN: if (word_ok) begin
        drain_nx = drain - 9'd1;
        if (drain == 9'd1) state_nx = S_HDR;
      end
      default: state_nx = S_HDR;
    endcase
  end

  always_comb begin
    resp_data = 16'h0000;
    case (state)
      S_ECHO:  resp_data = hdr;
      S_RLO:   resp_data = rdata[15:0];
      S_RHI:   resp_data = rdata[31:16];
      default: resp_data = 16'h0000;
    endcase
  end

  assign mem_valid  = (state == S_BUS);
  assign mem_wstrb  = (mem_valid && is_write) ? 4'hF : 4'h0;
  assign mem_addr   = addr;
  assign mem_wdata  = wdata;
  assign resp_valid = (state == S_ECHO) || (state == S_RLO) || (state == S_RHI);
  assign busy       = (state != S_HDR);

endmodule
